// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core memory system: RAM handshake states,
// arbiter states and the latched transaction record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DGRANT = 3'd1,
    IGRANT = 3'd2,
    FAULT  = 3'd3,
    PARKED = 3'd4
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEFAULT = 15;

  // Address, store data and op captured at grant time.
  typedef struct packed {
    word_t addr;
    word_t store;
    logic  wen;
  } arb_txn_t;

  function automatic arb_txn_t make_txn(word_t addr, word_t store, logic wen);
    arb_txn_t t;
    t.addr  = addr;
    t.store = store;
    t.wen   = wen;
    return t;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Memory-control bundle between datapath, arbiter and system RAM.
interface mem_ctrl_if;
  import cpu_types_pkg::*;

  logic      iREN, dREN, dWEN, halt;
  word_t     iaddr, daddr, dstore;
  ramstate_t ramstate;
  word_t     ramload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore;
  logic      ihit, dhit, err, halted;
  word_t     iload, dload;

  modport arbiter (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramstate, ramload,
    output ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, err, halted
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramstate, ramload
  );

endinterface

// File: rtl/arb_wait_counter.sv
// Saturating wait-cycle counter for a granted RAM transaction; flags the
// wait cycle that brings the count to TIMEOUT.
module arb_wait_counter
  import cpu_types_pkg::*;
#(
  parameter  int TIMEOUT = ARB_TIMEOUT_DEFAULT,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every signal written here gets its default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i && (count_q != CW'(TIMEOUT)))
      count_d = count_q + CW'(1);
  end

  // NOTE: clocked state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expired_o = en_i && (count_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access:
// data-favoured with a one-shot fetch token, error/timeout fault and halt park.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  input  ramstate_t   ramstate,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        err,
  output logic        halted
);

  arb_state_t state_q, state_d;
  logic       ifirst_q, ifirst_d;
  arb_txn_t   txn_q, txn_d;
  logic       cnt_clr, cnt_en, cnt_expired;
  logic       in_grant;

  arb_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk      (CLK),
    .rst_n    (nRST),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expired_o(cnt_expired)
  );

  always_comb begin
    state_d  = state_q;
    ifirst_d = ifirst_q;
    txn_d    = txn_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = PARKED;
        end else if (iREN && ifirst_q) begin
          state_d  = IGRANT;
          ifirst_d = 1'b0;
          txn_d    = make_txn(iaddr, '0, 1'b0);
          cnt_clr  = 1'b1;
        end else if (dREN || dWEN) begin
          state_d = DGRANT;
          txn_d   = make_txn(daddr, dstore, dWEN);
          cnt_clr = 1'b1;
        end else if (iREN) begin
          state_d  = IGRANT;
          ifirst_d = 1'b0;
          txn_d    = make_txn(iaddr, '0, 1'b0);
          cnt_clr  = 1'b1;
        end
      end
      DGRANT, IGRANT: begin
        if (ramstate == ACCESS) begin
          state_d = IDLE;
          // A fetch that waited behind this data access goes next.
          if (state_q == DGRANT && iREN) ifirst_d = 1'b1;
        end else if (ramstate == ERROR) begin
          state_d = FAULT;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) state_d = FAULT;
        end
      end
      FAULT, PARKED: state_d = state_q;
      default:       state_d = FAULT;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ifirst_q <= 1'b0;
      txn_q    <= '0;
    end else begin
      state_q  <= state_d;
      ifirst_q <= ifirst_d;
      txn_q    <= txn_d;
    end
  end

  // Outputs decode the registered state, so reset clears them asynchronously.
  assign in_grant = (state_q == DGRANT) || (state_q == IGRANT);
  assign ramREN   = (state_q == IGRANT) || ((state_q == DGRANT) && !txn_q.wen);
  assign ramWEN   = (state_q == DGRANT) && txn_q.wen;
  assign ramaddr  = in_grant ? txn_q.addr  : '0;
  assign ramstore = in_grant ? txn_q.store : '0;
  assign ihit     = (state_q == IGRANT) && (ramstate == ACCESS);
  assign dhit     = (state_q == DGRANT) && (ramstate == ACCESS);
  assign iload    = ihit ? ramload : '0;
  assign dload    = dhit ? ramload : '0;
  assign err      = (state_q == FAULT);
  assign halted   = (state_q == PARKED);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model with
// a per-cycle compare process, directed scenarios with literal expectations,
// and randomized traffic.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 15;

  logic      CLK  = 1'b0;
  logic      nRST = 1'b1;
  logic      iREN, dREN, dWEN, halt;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      ramREN, ramWEN, ihit, dhit, err, halted;
  word_t     ramaddr, ramstore, iload, dload;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .halt(halt), .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .err(err), .halted(halted)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit run_en      = 1'b0;

  task automatic check32(input string name, input word_t act, input word_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: at most one transaction in flight, plus sticky fault/park
  // flags and the fetch token.
  bit    m_busy, m_data, m_wen, m_fault, m_parked, m_ifirst;
  word_t m_addr, m_store;
  int    m_waits;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_busy <= 0; m_data <= 0; m_wen <= 0; m_fault <= 0; m_parked <= 0;
      m_ifirst <= 0; m_addr <= '0; m_store <= '0; m_waits <= 0;
    end else if (m_busy) begin
      if (ramstate == ACCESS) begin
        m_busy <= 0;
        if (m_data && iREN) m_ifirst <= 1;
      end else if (ramstate == ERROR) begin
        m_busy <= 0; m_fault <= 1;
      end else begin
        m_waits <= m_waits + 1;
        if (m_waits + 1 >= TO) begin m_busy <= 0; m_fault <= 1; end
      end
    end else if (!m_fault && !m_parked) begin
      if (halt) begin
        m_parked <= 1;
      end else if (iREN && (m_ifirst || !(dREN || dWEN))) begin
        m_busy <= 1; m_data <= 0; m_wen <= 0; m_addr <= iaddr; m_store <= '0;
        m_waits <= 0; m_ifirst <= 0;
      end else if (dREN || dWEN) begin
        m_busy <= 1; m_data <= 1; m_wen <= dWEN; m_addr <= daddr; m_store <= dstore;
        m_waits <= 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (run_en) begin
      logic hit;
      #2;
      hit = m_busy && (ramstate == ACCESS);
      check1 ("ramREN",   ramREN,   m_busy && !m_wen);
      check1 ("ramWEN",   ramWEN,   m_busy && m_wen);
      check32("ramaddr",  ramaddr,  m_busy ? m_addr  : '0);
      check32("ramstore", ramstore, m_busy ? m_store : '0);
      check1 ("ihit",     ihit,     hit && !m_data);
      check1 ("dhit",     dhit,     hit && m_data);
      check32("iload",    iload,    (hit && !m_data) ? ramload : '0);
      check32("dload",    dload,    (hit && m_data) ? ramload : '0);
      check1 ("err",      err,      m_fault);
      check1 ("halted",   halted,   m_parked);
    end
  end

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; halt = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 0;
    idle_inputs();
    #3;
    check1 ("rst_ramREN",  ramREN,  1'b0);
    check1 ("rst_ramWEN",  ramWEN,  1'b0);
    check32("rst_ramaddr", ramaddr, 32'h0);
    check1 ("rst_err",     err,     1'b0);
    check1 ("rst_halted",  halted,  1'b0);
    @(negedge CLK);
    nRST = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit    exp_d [5] = '{1, 0, 0, 0, 1};
    bit    exp_i [5] = '{0, 0, 1, 0, 0};
    word_t exp_a [5] = '{32'h100, 32'h0, 32'h44, 32'h0, 32'h100};

    idle_inputs();
    #1 nRST = 0;
    run_en = 1;
    do_reset();

    // Fetch only, zero-wait RAM; request dropped during the grant.
    iREN = 1; iaddr = 32'h40;
    @(negedge CLK);
    iREN = 0; ramstate = ACCESS; ramload = 32'h8C22_0004;
    #3;
    check1 ("f_ramREN", ramREN, 1'b1);
    check32("f_addr",   ramaddr, 32'h40);
    check1 ("f_ihit",   ihit, 1'b1);
    check32("f_iload",  iload, 32'h8C22_0004);
    @(negedge CLK);
    ramstate = FREE;
    #3;
    check1 ("f_ihit_once", ihit, 1'b0);
    check1 ("f_idle_ren",  ramREN, 1'b0);

    // Contention: data first, then fetch via token, then data again.
    do_reset();
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100;
    ramstate = ACCESS; ramload = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      #3;
      check1 ($sformatf("cont_dhit%0d", c), dhit, exp_d[c]);
      check1 ($sformatf("cont_ihit%0d", c), ihit, exp_i[c]);
      check32($sformatf("cont_addr%0d", c), ramaddr, exp_a[c]);
    end

    // Read+write together: write wins; three BUSY cycles then ACCESS.
    do_reset();
    dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ramstate = BUSY;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      if (c == 1) begin dREN = 0; dWEN = 0; end
      if (c == 4) ramstate = ACCESS;
      #3;
      check1 ($sformatf("w_wen%0d", c),   ramWEN, 1'b1);
      check1 ($sformatf("w_ren%0d", c),   ramREN, 1'b0);
      check32($sformatf("w_store%0d", c), ramstore, 32'hDEAD_BEEF);
      check1 ($sformatf("w_dhit%0d", c),  dhit, c == 4);
    end
    @(negedge CLK);
    ramstate = FREE;
    #3 check1("w_done_wen", ramWEN, 1'b0);

    // Timeout: fifteen BUSY wait cycles, then sticky fault.
    do_reset();
    iREN = 1; iaddr = 32'h300; ramstate = BUSY;
    for (int c = 1; c <= 16; c++) begin
      @(negedge CLK);
      #3;
      check1($sformatf("to_err%0d", c), err, c == 16);
      check1($sformatf("to_ren%0d", c), ramREN, c <= 15);
    end
    ramstate = ACCESS;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #3;
      check1("to_nohit", ihit, 1'b0);
      check1("to_sticky", err, 1'b1);
    end

    // Halt during a fetch: fetch completes, then park.
    do_reset();
    iREN = 1; iaddr = 32'h80; ramstate = BUSY;
    @(negedge CLK);
    iREN = 0; halt = 1;
    #3 check1("h_ren", ramREN, 1'b1);
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h2;
    #3;
    check1("h_ihit", ihit, 1'b1);
    check1("h_not_yet", halted, 1'b0);
    @(negedge CLK);
    ramstate = FREE;
    #3 check1("h_idle", halted, 1'b0);
    @(negedge CLK);
    halt = 0; iREN = 1; ramstate = ACCESS;
    #3 check1("h_parked", halted, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #3;
      check1("h_ren_off", ramREN, 1'b0);
      check1("h_nohit", ihit, 1'b0);
    end

    // Asynchronous reset in the middle of a BUSY write.
    do_reset();
    dWEN = 1; daddr = 32'h400; dstore = 32'h55; ramstate = BUSY;
    @(negedge CLK);
    #3 check1("ar_wen_before", ramWEN, 1'b1);
    @(negedge CLK);
    #1 nRST = 0;
    #1;
    check1 ("ar_wen",   ramWEN, 1'b0);
    check32("ar_addr",  ramaddr, 32'h0);
    check32("ar_store", ramstore, 32'h0);
    check1 ("ar_dhit",  dhit, 1'b0);
    @(negedge CLK);
    #3 check1("ar_wen_held", ramWEN, 1'b0);
    @(negedge CLK);
    idle_inputs();
    nRST = 1;

    // Randomized traffic, checked cycle by cycle against the model.
    for (int b = 0; b < 6; b++) begin
      do_reset();
      for (int n = 0; n < 300; n++) begin
        int r;
        @(negedge CLK);
        iREN   = ($urandom_range(0, 2) != 0);
        dREN   = ($urandom_range(0, 1) != 0);
        dWEN   = ($urandom_range(0, 3) == 0);
        iaddr  = $urandom;
        daddr  = $urandom;
        dstore = $urandom;
        ramload = $urandom;
        halt   = ($urandom_range(0, 299) == 0);
        r = $urandom_range(0, 99);
        if (b == 5) ramstate = (r < 4) ? ACCESS : BUSY;
        else if (r < 45) ramstate = ACCESS;
        else if (r < 85) ramstate = BUSY;
        else if (r < 99) ramstate = FREE;
        else             ramstate = ERROR;
      end
    end

    @(negedge CLK);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
